// File: rtl/btn_event_pkg.sv
// Shared types and constants for the button event arbiter.
// Optional release events are enabled with BTN_EVENT_ARBITER_RELEASE_EN.
package btn_event_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_e;

   localparam int DEF_NUM_IN    = 4;
   localparam int DEF_DB_CYCLES = 16;

   // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One button: 2-flop synchroniser, counter debounce and edge detect.
// With BTN_EVENT_ARBITER_RELEASE_EN a falling-edge strobe is also produced.
module btn_conditioner
   import btn_event_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_db_state,
   output logic o_rise
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
   ,output logic o_fall
`endif
);

   localparam int                 CNT_W   = clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_db_state;
   logic             r_db_q;
   logic [CNT_W-1:0] r_cnt;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_db_state <= 1'b0;
         r_db_q     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_s1   <= i_btn;
         r_s2   <= r_s1;
         r_db_q <= r_db_state;
         // The new level must hold for DB_CYCLES consecutive clocks.
         if (r_s2 == r_db_state) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_db_state <= r_s2;
            r_cnt      <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_db_state = r_db_state;
   assign o_rise     = r_db_state & ~r_db_q;
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
   assign o_fall     = ~r_db_state & r_db_q;
`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// Conditions NUM_IN buttons, latches one pending event each and serialises
// them round-robin over valid/ready. BTN_EVENT_ARBITER_RELEASE_EN adds release events.
module btn_event_arbiter
   import btn_event_pkg::*;
#(
   parameter int NUM_IN    = DEF_NUM_IN,
   parameter int DB_CYCLES = DEF_DB_CYCLES,
   parameter int IDX_W     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_IN-1:0] btn_in,
   output logic              evt_valid,
   output logic [IDX_W-1:0]  evt_idx,
   input  logic              evt_ready,
   output logic [NUM_IN-1:0] pending,
   output logic              overflow
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
   ,output logic             evt_level
`endif
);

   logic [NUM_IN-1:0] w_db_state;
   logic [NUM_IN-1:0] w_rise;
   logic [NUM_IN-1:0] w_event;
   logic [NUM_IN-1:0] w_clear;
   logic              w_handshake;

   logic [NUM_IN-1:0] r_pending;
   logic              r_overflow;
   state_e            r_state;
   state_e            w_state_next;
   logic [IDX_W-1:0]  r_evt_idx;
   logic [IDX_W-1:0]  w_idx_next;
   logic [IDX_W-1:0]  r_last;
   logic [IDX_W-1:0]  w_last_next;
   logic              w_grant_found;
   logic [IDX_W-1:0]  w_grant_idx;
   logic [IDX_W-1:0]  w_cand;

`ifdef BTN_EVENT_ARBITER_RELEASE_EN
   logic [NUM_IN-1:0] w_fall;
   logic              r_evt_level;
   logic              w_level_next;
`endif

   for (genvar g = 0; g < NUM_IN; g++) begin : g_cond
      btn_conditioner #(
         .DB_CYCLES (DB_CYCLES)
      ) u_cond (
         .clk        (clk),
         .rst        (rst),
         .i_btn      (btn_in[g]),
         .o_db_state (w_db_state[g]),
         .o_rise     (w_rise[g])
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
         ,.o_fall    (w_fall[g])
`endif
      );
   end

`ifdef BTN_EVENT_ARBITER_RELEASE_EN
   assign w_event = w_rise | w_fall;
`else
   assign w_event = w_rise;
`endif

   assign w_handshake = (r_state == ST_OFFER) && evt_ready;
   assign w_clear     = w_handshake ? (NUM_IN'(1) << r_evt_idx) : '0;

   // A new edge on a bit being served re-arms it; on a still-unserved bit it is merged and lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_pending  <= (r_pending & ~w_clear) | w_event;
         r_overflow <= r_overflow | (|(w_event & r_pending & ~w_clear));
      end
   end

   // Round-robin: first pending bit strictly after the last served index, wrapping.
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_cand        = '0;
      for (int off = 1; off <= NUM_IN; off++) begin
         w_cand = IDX_W'((int'(r_last) + off) % NUM_IN);
         if (!w_grant_found && r_pending[w_cand]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = w_cand;
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_evt_idx;
      w_last_next  = r_last;
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
      w_level_next = r_evt_level;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_grant_found) begin
               w_state_next = ST_OFFER;
               w_idx_next   = w_grant_idx;
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
               w_level_next = w_db_state[w_grant_idx];
`endif
            end
         end
         ST_OFFER: begin
            if (evt_ready) begin
               w_state_next = ST_IDLE;
               w_last_next  = r_evt_idx;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: last resets to NUM_IN-1 so that index 0 wins the first arbitration.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_evt_idx <= '0;
         r_last    <= IDX_W'(NUM_IN - 1);
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
         r_evt_level <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_next;
         r_evt_idx <= w_idx_next;
         r_last    <= w_last_next;
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
         r_evt_level <= w_level_next;
`endif
      end
   end

   assign evt_valid = (r_state == ST_OFFER);
   assign evt_idx   = r_evt_idx;
   assign pending   = r_pending;
   assign overflow  = r_overflow;
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
   assign evt_level = r_evt_level;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter (NUM_IN=4, DB_CYCLES=4), default build.
module tb_btn_event_arbiter;

   localparam int NUM_IN    = 4;
   localparam int DB_CYCLES = 4;
   localparam int IDX_W     = 2;

   logic              clk;
   logic              rst;
   logic [NUM_IN-1:0] btn_in;
   logic              evt_valid;
   logic [IDX_W-1:0]  evt_idx;
   logic              evt_ready;
   logic [NUM_IN-1:0] pending;
   logic              overflow;
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
   logic              evt_level;
`endif

   int tests;
   int fails;
   int hs_count;
   int cycle_cnt;
   int exp_idx;
   int exp_q[$];
   int hs_times[$];

   btn_event_arbiter #(
      .NUM_IN    (NUM_IN),
      .DB_CYCLES (DB_CYCLES),
      .IDX_W     (IDX_W)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .evt_valid (evt_valid),
      .evt_idx   (evt_idx),
      .evt_ready (evt_ready),
      .pending   (pending),
      .overflow  (overflow)
`ifdef BTN_EVENT_ARBITER_RELEASE_EN
      ,.evt_level (evt_level)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle_cnt++;

   // Handshake monitor: a transfer happens at the next posedge; compare with scoreboard.
   always @(negedge clk) begin
      if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
         hs_count++;
         hs_times.push_back(cycle_cnt);
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got idx %0d, expected no event", evt_idx);
         end else begin
            exp_idx = exp_q.pop_front();
            if (evt_idx !== exp_idx[IDX_W-1:0]) begin
               fails++;
               $display("FAIL event_idx: got %0d, expected %0d", evt_idx, exp_idx);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
      $fatal(1);
   end

   task automatic test_reset();
      rst       = 1'b1;
      btn_in    = '0;
      evt_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         tests++;
         if (evt_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b, expected 0", evt_valid);
         end
         tests++;
         if (pending !== 4'b0000) begin
            fails++;
            $display("FAIL reset_pending: got %b, expected 0000", pending);
         end
         tests++;
         if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_overflow: got %b, expected 0", overflow);
         end
         tests++;
         if (evt_idx !== 2'd0) begin
            fails++;
            $display("FAIL reset_idx: got %0d, expected 0", evt_idx);
         end
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic end_scenario(input string name, input int start_hs, input int n_exp);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_missing: got %0d events still outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      tests++;
      if (hs_count - start_hs != n_exp) begin
         fails++;
         $display("FAIL %s_count: got %0d events, expected %0d", name, hs_count - start_hs, n_exp);
      end
   endtask

   task automatic test_single_press();
      int start_hs;
      test_reset();
      start_hs  = hs_count;
      evt_ready = 1'b1;
      btn_in[2] = 1'b1;
      exp_q.push_back(2);
      repeat (6) @(posedge clk);
      @(negedge clk);
      tests++;
      if (pending !== 4'b0000) begin
         fails++;
         $display("FAIL latency_pending_early: got %b after edge 5, expected 0000", pending);
      end
      @(negedge clk);
      tests++;
      if (pending !== 4'b0100 || evt_valid !== 1'b0) begin
         fails++;
         $display("FAIL latency_pending: got pending %b valid %b after edge 6, expected 0100 0", pending, evt_valid);
      end
      @(negedge clk);
      tests++;
      if (evt_valid !== 1'b1 || evt_idx !== 2'd2) begin
         fails++;
         $display("FAIL latency_valid: got valid %b idx %0d after edge 7, expected 1 2", evt_valid, evt_idx);
      end
      repeat (20) @(negedge clk);
      tests++;
      if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_idle: got pending %b valid %b, expected 0000 0", pending, evt_valid);
      end
      end_scenario("single", start_hs, 1);
   endtask

   task automatic test_glitch();
      int start_hs;
      int bad;
      test_reset();
      start_hs  = hs_count;
      evt_ready = 1'b1;
      bad       = 0;
      btn_in[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1 btn_in[1] = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (pending !== 4'b0000) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL glitch_pending: got %0d cycles with pending set, expected 0", bad);
      end
      end_scenario("glitch", start_hs, 0);
   endtask

   task automatic test_round_robin();
      int start_hs;
      test_reset();
      start_hs  = hs_count;
      hs_times.delete();
      evt_ready = 1'b1;
      btn_in    = 4'b1001;
      exp_q.push_back(0);
      exp_q.push_back(3);
      repeat (16) @(negedge clk);
      tests++;
      if (hs_times.size() != 2) begin
         fails++;
         $display("FAIL rr_pair_count: got %0d events, expected 2", hs_times.size());
      end else begin
         tests++;
         if (hs_times[1] - hs_times[0] != 2) begin
            fails++;
            $display("FAIL rr_spacing: got %0d cycles apart, expected 2", hs_times[1] - hs_times[0]);
         end
      end
      @(posedge clk);
      #1 btn_in = 4'b0000;
      repeat (10) @(posedge clk);
      #1 btn_in = 4'b1010;
      exp_q.push_back(1);
      exp_q.push_back(3);
      repeat (16) @(negedge clk);
      end_scenario("round_robin", start_hs, 4);
   endtask

   task automatic hold_check(input int n, inout int bad);
      repeat (n) begin
         @(negedge clk);
         if (evt_valid !== 1'b1 || evt_idx !== 2'd1) bad++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      int start_hs;
      int bad;
      test_reset();
      start_hs  = hs_count;
      evt_ready = 1'b0;
      bad       = 0;
      btn_in[1] = 1'b1;
      exp_q.push_back(1);
      repeat (10) @(posedge clk);
      #1 btn_in[1] = 1'b0;
      hold_check(10, bad);
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL overflow_early: got %b before second press, expected 0", overflow);
      end
      btn_in[1] = 1'b1;
      hold_check(12, bad);
      tests++;
      if (overflow !== 1'b1) begin
         fails++;
         $display("FAIL overflow_set: got %b after second press, expected 1", overflow);
      end
      hold_check(8, bad);
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL offer_hold: got %0d unstable cycles over 30, expected 0", bad);
      end
      tests++;
      if (hs_count != start_hs) begin
         fails++;
         $display("FAIL offer_no_ready: got %0d events while ready low, expected 0", hs_count - start_hs);
      end
      evt_ready = 1'b1;
      repeat (12) @(negedge clk);
      tests++;
      if (pending !== 4'b0000 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL backpressure_after: got pending %b overflow %b, expected 0000 1", pending, overflow);
      end
      end_scenario("backpressure", start_hs, 1);
   endtask

   task automatic test_reset_mid_offer();
      int start_hs;
      test_reset();
      start_hs  = hs_count;
      evt_ready = 1'b0;
      btn_in[2] = 1'b1;
      repeat (10) @(negedge clk);
      tests++;
      if (evt_valid !== 1'b1 || evt_idx !== 2'd2) begin
         fails++;
         $display("FAIL pre_reset_offer: got valid %b idx %0d, expected 1 2", evt_valid, evt_idx);
      end
      @(posedge clk);
      #1;
      rst    = 1'b1;
      btn_in = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
         fails++;
         $display("FAIL mid_reset: got valid %b pending %b, expected 0 0000", evt_valid, pending);
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      evt_ready = 1'b1;
      repeat (20) @(negedge clk);
      tests++;
      if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
         fails++;
         $display("FAIL post_reset_idle: got valid %b pending %b, expected 0 0000", evt_valid, pending);
      end
      end_scenario("reset_mid_offer", start_hs, 0);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      hs_count  = 0;
      cycle_cnt = 0;
      rst       = 1'b1;
      btn_in    = '0;
      evt_ready = 1'b0;
      test_reset();
      test_single_press();
      test_glitch();
      test_round_robin();
      test_backpressure();
      test_reset_mid_offer();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
